// File: rtl/snow64_instr_fetch_queue_pkg.sv
// Shared types and constants for the Snow64 fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snow64_instr_fetch_queue_pkg;

  localparam int WIDTH__ADDR        = 64;
  localparam int WIDTH__INSTR       = 32;
  localparam int WIDTH__INSTR_BYTES = 4;

  typedef enum logic {
    StFetchRun   = 1'b0,
    StFetchDrain = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WIDTH__INSTR-1:0] instr;
    logic [WIDTH__ADDR-1:0]  pc;
  } FetchQueueEntry;

  // Sequential successor of a word-aligned PC; wraps modulo 2^WIDTH__ADDR.
  function automatic logic [WIDTH__ADDR-1:0] next_pc(input logic [WIDTH__ADDR-1:0] pc);
    return pc + WIDTH__ADDR'(WIDTH__INSTR_BYTES);
  endfunction

endpackage

// File: rtl/snow64_instr_fetch_queue_if.sv
// Bundle of redirect, memory request/response and decoder handshake signals.
// Latency: n/a (wiring only).
// Backpressure: mem request valid/ready, decoder valid/ready; responses carry no ready.
// master = fetch queue side, slave = environment (EX, memory, decoder).
interface snow64_instr_fetch_queue_if;
  import snow64_instr_fetch_queue_pkg::*;

  logic                    in_redirect_valid;
  logic [WIDTH__ADDR-1:0]  in_redirect_addr;
  logic                    out_mem_req_valid;
  logic                    in_mem_req_ready;
  logic [WIDTH__ADDR-1:0]  out_mem_req_addr;
  logic                    in_mem_resp_valid;
  logic [WIDTH__INSTR-1:0] in_mem_resp_data;
  logic                    out_instr_valid;
  logic [WIDTH__INSTR-1:0] out_instr;
  logic [WIDTH__ADDR-1:0]  out_instr_pc;
  logic                    in_instr_ready;

  modport master (
    input  in_redirect_valid, in_redirect_addr,
    output out_mem_req_valid, out_mem_req_addr,
    input  in_mem_req_ready,
    input  in_mem_resp_valid, in_mem_resp_data,
    output out_instr_valid, out_instr, out_instr_pc,
    input  in_instr_ready
  );

  modport slave (
    output in_redirect_valid, in_redirect_addr,
    input  out_mem_req_valid, out_mem_req_addr,
    output in_mem_req_ready,
    output in_mem_resp_valid, in_mem_resp_data,
    input  out_instr_valid, out_instr, out_instr_pc,
    output in_instr_ready
  );

endinterface

// File: rtl/snow64_fetch_fifo.sv
// Synchronous FIFO of FetchQueueEntry with flush; head is read straight from storage registers.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller's credit scheme keeps push off a full FIFO.
// Ports: clk, rst (async, active-high), push/push_entry, pop, flush, head, empty, occupancy.
module snow64_fetch_fifo
  import snow64_instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  FetchQueueEntry           push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output FetchQueueEntry           head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  FetchQueueEntry  mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);
  assign occupancy = count;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                   !(push && !pop && !flush && (count == (AW+1)'(DEPTH))));

endmodule

// File: rtl/snow64_instr_fetch_queue.sv
// Sequential instruction fetch with credit-limited requests, in-order response FIFO and redirect flush.
// Latency: redirect target reaches out_instr_valid 3 cycles after the redirect (1-cycle memory, idle queue).
// Backpressure: requests stop when in_flight + occupancy reaches DEPTH; decoder stalls via in_instr_ready.
// Ports: clk, rst (async, active-high), bus (snow64_instr_fetch_queue_if.master).
module snow64_instr_fetch_queue
  import snow64_instr_fetch_queue_pkg::*;
#(
  parameter int                     DEPTH    = 4,
  parameter logic [WIDTH__ADDR-1:0] RESET_PC = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  snow64_instr_fetch_queue_if.master      bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t           state;
  logic [WIDTH__ADDR-1:0] fetch_pc;
  logic [WIDTH__ADDR-1:0] resp_pc;
  logic [CW-1:0]          in_flight;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          occupancy;
  logic [CW-1:0]          drop_next;
  logic [WIDTH__ADDR-1:0] redirect_target;
  logic                   credit_ok;
  logic                   req_fire;
  logic                   resp_ok;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  FetchQueueEntry         push_entry;
  FetchQueueEntry         head;

  // Outstanding requests plus buffered words never exceed DEPTH, so every response has a slot.
  assign credit_ok = ({1'b0, in_flight} + {1'b0, occupancy}) < (CW+1)'(DEPTH);

  // Gated by rst so the request line drops the instant reset asserts.
  assign bus.out_mem_req_valid = !rst && (state == StFetchRun) && !bus.in_redirect_valid && credit_ok;
  assign bus.out_mem_req_addr  = fetch_pc;
  assign req_fire              = bus.out_mem_req_valid && bus.in_mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = bus.in_mem_resp_valid && (in_flight != '0);
  assign drop_next = in_flight - CW'(resp_ok);

  assign redirect_target = bus.in_redirect_addr & ~WIDTH__ADDR'(3);

  assign fifo_push  = resp_ok && (state == StFetchRun) && !bus.in_redirect_valid;
  assign fifo_pop   = !fifo_empty && bus.in_instr_ready && !bus.in_redirect_valid;
  assign push_entry = '{instr: bus.in_mem_resp_data, pc: resp_pc};

  snow64_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (bus.in_redirect_valid),
    .head       (head),
    .empty      (fifo_empty),
    .occupancy  (occupancy)
  );

  assign bus.out_instr_valid = !fifo_empty;
  assign bus.out_instr       = head.instr;
  assign bus.out_instr_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StFetchRun;
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else if (bus.in_redirect_valid) begin
      // Everything still outstanding is stale; the in-cycle response is discarded too.
      fetch_pc  <= redirect_target;
      resp_pc   <= redirect_target;
      in_flight <= drop_next;
      drop_cnt  <= drop_next;
      state     <= (drop_next != '0) ? StFetchDrain : StFetchRun;
    end else begin
      case (state)
        StFetchRun: begin
          if (req_fire) fetch_pc <= next_pc(fetch_pc);
          if (resp_ok)  resp_pc  <= next_pc(resp_pc);
          in_flight <= in_flight + CW'(req_fire) - CW'(resp_ok);
        end
        StFetchDrain: begin
          // No requests issue here, so drop_cnt tracks in_flight exactly.
          if (resp_ok) begin
            drop_cnt  <= drop_cnt - CW'(1);
            in_flight <= in_flight - CW'(1);
            if (drop_cnt == CW'(1)) state <= StFetchRun;
          end
        end
        default: state <= StFetchRun;
      endcase
    end
  end

  a_resp_outstanding: assert property (@(posedge clk) disable iff (rst)
                                       !(bus.in_mem_resp_valid && (in_flight == '0)));

endmodule

// File: tb/tb_snow64_instr_fetch_queue.sv
// Self-checking bench for snow64_instr_fetch_queue: vector table plus directed redirect/reset sequences.
// Latency: memory model answers one cycle after each accepted request unless held.
// Backpressure: memory and decoder ready are driven per cycle from the stimulus.
module tb_snow64_instr_fetch_queue;
  import snow64_instr_fetch_queue_pkg::*;

  typedef struct {
    logic        mr;
    logic        ir;
    logic        exp_rv;
    logic [63:0] exp_ra;
    logic        exp_iv;
    logic [63:0] exp_ipc;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snow64_instr_fetch_queue_if bus();

  snow64_instr_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] memq[$];
  exp_t        expq[$];
  logic        hold = 1'b0;
  logic        resp_drv;
  logic        s_rv, s_fire, s_iv, s_pop;
  logic [63:0] s_ra, s_ipc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: entered and left at negedge, with the control inputs already set.
  task automatic step();
    exp_t e;
    resp_drv = !hold && (memq.size() > 0);
    bus.in_mem_resp_valid = resp_drv;
    bus.in_mem_resp_data  = resp_drv ? mem_word(memq[0]) : 32'h0;
    #1;
    s_rv   = bus.out_mem_req_valid;
    s_ra   = bus.out_mem_req_addr;
    s_fire = s_rv && bus.in_mem_req_ready;
    s_iv   = bus.out_instr_valid;
    s_ipc  = bus.out_instr_pc;
    s_pop  = s_iv && bus.in_instr_ready && !bus.in_redirect_valid;
    if (bus.in_redirect_valid) begin
      expq.delete();
    end else if (s_pop) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: pc %h emitted, nothing expected", s_ipc);
      end else begin
        e = expq.pop_front();
        chk("sb_pc", s_ipc, e.pc);
        chk("sb_instr", 64'(bus.out_instr), 64'(e.instr));
      end
    end
    if (s_fire) begin
      memq.push_back(s_ra);
      e.pc    = s_ra;
      e.instr = mem_word(s_ra);
      expq.push_back(e);
    end
    @(posedge clk);
    if (resp_drv) void'(memq.pop_front());
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(input logic [63:0] addr);
    bus.in_redirect_valid = 1'b1;
    bus.in_redirect_addr  = addr;
    step();
    bus.in_redirect_valid = 1'b0;
    bus.in_redirect_addr  = 64'h0;
  endtask

  // Runs up to n cycles, returning the first fetch address and first emitted PC.
  task automatic run_capture(input int n, output logic got_a, output logic [63:0] fa,
                             output logic got_p, output logic [63:0] fp);
    got_a = 1'b0; fa = '0; got_p = 1'b0; fp = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (s_fire && !got_a) begin got_a = 1'b1; fa = s_ra; end
      if (s_pop && !got_p) begin got_p = 1'b1; fp = s_ipc; end
    end
  endtask

  vec_t        tbl[12];
  logic        ga, gp;
  logic [63:0] fa, fp;
  int          lat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ready-low burst then release: DEPTH requests, stall, in-order drain, resume
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 64'h00, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 64'h04, 1'b0, 64'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 64'h08, 1'b1, 64'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 64'h0C, 1'b1, 64'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 64'h00, 1'b1, 64'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 64'h00, 1'b1, 64'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 64'h00, 1'b1, 64'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 64'h00, 1'b1, 64'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h4};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'h8};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 64'h18, 1'b1, 64'hC};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 64'h1C, 1'b1, 64'h10};

    rst = 1'b0;
    bus.in_redirect_valid = 1'b0;
    bus.in_redirect_addr  = 64'h0;
    bus.in_mem_req_ready  = 1'b0;
    bus.in_mem_resp_valid = 1'b0;
    bus.in_mem_resp_data  = 32'h0;
    bus.in_instr_ready    = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_req_valid",   64'(bus.out_mem_req_valid), 64'h0);
    chk("rst_instr_valid", 64'(bus.out_instr_valid), 64'h0);
    chk("rst_instr",       64'(bus.out_instr), 64'h0);
    chk("rst_instr_pc",    bus.out_instr_pc, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.in_mem_req_ready = tbl[i].mr;
      bus.in_instr_ready   = tbl[i].ir;
      step();
      chk("tbl_req_valid", 64'(s_rv), 64'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk("tbl_req_addr", s_ra, tbl[i].exp_ra);
      chk("tbl_instr_valid", 64'(s_iv), 64'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) chk("tbl_instr_pc", s_ipc, tbl[i].exp_ipc);
    end
    steps(8);

    // Redirect to 0x1003 with two requests outstanding
    bus.in_mem_req_ready = 1'b0;
    steps(6);
    hold = 1'b1;
    bus.in_mem_req_ready = 1'b1;
    steps(2);
    chk("c_in_flight", 64'(dut.in_flight), 64'd2);
    redirect(64'h1003);
    chk("c_state_drain", 64'(dut.state == StFetchDrain), 64'h1);
    chk("c_drop_cnt", 64'(dut.drop_cnt), 64'd2);
    hold = 1'b0;
    step();
    chk("c_no_req_in_drain", 64'(s_rv), 64'h0);
    run_capture(10, ga, fa, gp, fp);
    chk("c_fetch_seen", 64'(ga), 64'h1);
    chk("c_first_addr", fa, 64'h1000);
    chk("c_pop_seen", 64'(gp), 64'h1);
    chk("c_first_pc", fp, 64'h1000);

    // Redirect latency from an idle queue
    bus.in_mem_req_ready = 1'b0;
    steps(6);
    chk("l_idle_in_flight", 64'(dut.in_flight), 64'h0);
    chk("l_idle_empty", 64'(bus.out_instr_valid), 64'h0);
    bus.in_mem_req_ready = 1'b1;
    redirect(64'h4002);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (s_iv && lat == 0) lat = k;
    end
    chk("l_latency", 64'(lat), 64'd3);

    // Redirect together with a response and a decoder pop
    bus.in_instr_ready = 1'b0;
    step();
    bus.in_instr_ready = 1'b1;
    hold = 1'b1;
    step();
    hold = 1'b0;
    chk("d_in_flight", 64'(dut.in_flight), 64'd2);
    redirect(64'h3000);
    chk("d_head_was_valid", 64'(s_iv), 64'h1);
    chk("d_flushed", 64'(bus.out_instr_valid), 64'h0);
    chk("d_drop_cnt", 64'(dut.drop_cnt), 64'd1);
    chk("d_state_drain", 64'(dut.state == StFetchDrain), 64'h1);
    run_capture(8, ga, fa, gp, fp);
    chk("d_first_pc", fp, 64'h3000);

    // Second redirect while draining
    bus.in_mem_req_ready = 1'b0;
    steps(6);
    hold = 1'b1;
    bus.in_mem_req_ready = 1'b1;
    steps(3);
    redirect(64'h5000);
    chk("e_drop_first", 64'(dut.drop_cnt), 64'd3);
    hold = 1'b0;
    step();
    chk("e_drop_after_one", 64'(dut.drop_cnt), 64'd2);
    redirect(64'h2000);
    chk("e_drop_recomputed", 64'(dut.drop_cnt), 64'd1);
    chk("e_state_drain", 64'(dut.state == StFetchDrain), 64'h1);
    run_capture(10, ga, fa, gp, fp);
    chk("e_first_addr", fa, 64'h2000);
    chk("e_first_pc", fp, 64'h2000);

    // Asynchronous reset mid-burst
    bus.in_instr_ready = 1'b0;
    step();
    bus.in_instr_ready = 1'b1;
    bus.in_mem_resp_valid = 1'b0;
    #2;
    chk("f_fifo_nonempty", 64'(bus.out_instr_valid), 64'h1);
    rst = 1'b1;
    #1;
    chk("f_req_valid", 64'(bus.out_mem_req_valid), 64'h0);
    chk("f_instr_valid", 64'(bus.out_instr_valid), 64'h0);
    chk("f_instr", 64'(bus.out_instr), 64'h0);
    chk("f_instr_pc", bus.out_instr_pc, 64'h0);
    memq.delete();
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("f_restart_fire", 64'(s_fire), 64'h1);
    chk("f_restart_addr", s_ra, 64'h0);
    steps(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
